delay_line_ctrl: RTL and testbench

//  Sequences a dual-port RAM (one write port, one synchronous read port) as a circular delay buffer.

---
 rtl/delay_line_ctrl.sv | 77 +++++++
 tb/tb_delay_line_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: sequences a 1W/1R synchronous dual-port RAM as a circular delay buffer of eff_off samples
//   clk, rst_n (sync, active-low); en/sample_in/offset: input strobe, sample and requested delay
//   ram_wr_en/ram_wr_addr/ram_din, ram_rd_en/ram_rd_addr, ram_dout: RAM interface (read data 1 clk after ram_rd_en)
//   sample_out/sample_out_valid: delayed sample, 1 clk after its strobe; primed: high in RUN
//   FILL_MUTE_EN: when defined, strobes that issue no read still produce a valid zero output
module delay_line_ctrl #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0]    sample_in,
  output logic                     ram_wr_en,
  output logic                     ram_rd_en,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic [DATA_WIDTH-1:0]    sample_out,
  output logic                     sample_out_valid,
  output logic                     primed
);
  localparam int AW = ADDRESS_WIDTH;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t state_q;
  logic [AW-1:0] wr_ptr_q, fill_cnt_q, offset_q, eff_off, new_eff, fill_nxt;
  logic rd_pend_q, offset_chg;
  assign eff_off = (offset_q == '0) ? AW'(1) : offset_q;
  assign new_eff = (offset == '0) ? AW'(1) : offset;
  assign fill_nxt = fill_cnt_q + 1'b1;
  assign offset_chg = (state_q != IDLE) && (offset != offset_q);
  assign ram_wr_en = en && rst_n;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_din = sample_in;
  assign ram_rd_addr = wr_ptr_q - eff_off;
  assign ram_rd_en = en && rst_n && (state_q == RUN) && !offset_chg;
  assign primed = (state_q == RUN);
  assign sample_out = rd_pend_q ? ram_dout : '0;
`ifdef FILL_MUTE_EN
  logic mute_pend_q;
  assign sample_out_valid = rd_pend_q | mute_pend_q;
  always_ff @(posedge clk)
    if (!rst_n) mute_pend_q <= 1'b0;
    else mute_pend_q <= en && !ram_rd_en;
`else
  assign sample_out_valid = rd_pend_q;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      fill_cnt_q <= '0;
      offset_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      if (en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (state_q == IDLE) begin
        if (en) begin
          offset_q <= offset;
          fill_cnt_q <= AW'(1);
          state_q <= (new_eff == AW'(1)) ? RUN : FILL;
        end
      end else if (offset_chg) begin
        // a strobe coinciding with the change is the first sample of the new fill
        offset_q <= offset;
        fill_cnt_q <= en ? AW'(1) : '0;
        state_q <= (new_eff == AW'(1)) ? RUN : FILL;
      end else if (state_q == FILL && en) begin
        fill_cnt_q <= fill_nxt;
        if (fill_nxt == eff_off) state_q <= RUN;
      end
      rd_pend_q <= ram_rd_en;
    end
  end
endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl: randomized check of delay_line_ctrl against a sample-history reference model
module tb_delay_line_ctrl;
  localparam int AW = 9, DW = 8, D = 1 << AW;
`ifdef FILL_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif
  logic clk = 0, rst_n = 0, en = 0;
  logic [AW-1:0] offset = '0;
  logic [DW-1:0] sample_in = '0;
  logic ram_wr_en, ram_rd_en, sample_out_valid, primed;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_din, ram_dout, sample_out;
  logic [DW-1:0] mem [D];
  int tests = 0, fails = 0;
  int n, seg, eff;
  bit started;
  logic [AW-1:0] cur_off;
  logic [DW-1:0] hist [4096];
  always #5 clk = ~clk;
  delay_line_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .offset(offset), .sample_in(sample_in),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_wr_addr(ram_wr_addr),
    .ram_rd_addr(ram_rd_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid), .primed(primed)
  );
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
    if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    n = 0; seg = 0; eff = 1; started = 0; cur_off = '0;
  endtask
  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst_n = 0; en = 1; sample_in = DW'($urandom);
      #1 chk("rst_wr_en", ram_wr_en, 0);
      chk("rst_rd_en", ram_rd_en, 0);
      @(posedge clk);
      #1 chk("rst_valid", sample_out_valid, 0);
      chk("rst_primed", primed, 0);
    end
    @(negedge clk);
    rst_n = 1; en = 0;
    model_reset();
  endtask
  // One cycle: drive, check RAM drive against the model, advance the model, check the output.
  task automatic step(input bit e, input logic [AW-1:0] off, input logic [DW-1:0] s);
    bit chg, rd, ev;
    logic [DW-1:0] ed;
    @(negedge clk);
    en = e; sample_in = s;
    if (e) offset = off;
    #1;
    chg = started && offset != cur_off;
    rd = e && started && !chg && seg >= eff;
    chk("primed", primed, started && seg >= eff);
    chk("wr_en", ram_wr_en, e);
    chk("rd_en", ram_rd_en, rd);
    if (e) begin
      chk("wr_addr", ram_wr_addr, n % D);
      chk("din", ram_din, s);
    end
    if (rd) chk("rd_addr", ram_rd_addr, (n - eff) % D);
    ev = MUTE ? e : rd;
    ed = rd ? hist[n - eff] : '0;
    if (e) hist[n] = s;
    if (!started) begin
      if (e) begin
        started = 1; cur_off = offset; seg = 1;
      end
    end else if (chg) begin
      cur_off = offset; seg = e ? 1 : 0;
    end else if (e) seg++;
    eff = (cur_off == 0) ? 1 : int'(cur_off);
    if (e) n++;
    @(posedge clk);
    #1 chk("valid", sample_out_valid, ev);
    chk("data", sample_out, ed);
  endtask
  initial begin
    model_reset();
    do_reset();
    for (int i = 1; i <= 20; i++) step(1, 4, DW'(i));
    step(1, 8, 8'hA5);
    for (int i = 0; i < 30; i++) step(1, 8, DW'(100 + i));
    for (int i = 0; i < 6; i++) step(0, 8, 8'h00);
    do_reset();
    for (int i = 0; i < 36; i++) step(i % 3 == 0, 0, DW'(i + 50));
    do_reset();
    for (int i = 0; i < 1200; i++) step(1, 510, DW'(i));
    do_reset();
    for (int i = 0; i < 500; i++) begin
      logic [AW-1:0] o;
      o = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(0, 12)) : offset;
      step($urandom_range(0, 9) < 7, o, DW'($urandom));
    end
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] o;
      o = ($urandom_range(0, 29) == 0) ? AW'($urandom_range(0, 20)) : offset;
      step($urandom_range(0, 9) < 8, o, DW'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
